// File: rtl/roi_crop_queue.sv
// roi_crop_queue: queues clamped bounding boxes and crops one source
// frame per box into a pixel stream tagged with its width/height.
//   box in  : valid_in/ready_out, HorMinIn/HorMaxIn, VerMinIn/VerMaxIn
//   source  : frame_request out; pixel_in, de_in, vsync_in in
//   crop out: ready_in in; valid_out, pixel_out, de_out, vsync_out,
//             OutWidth, OutHeight, roi_error out
module roi_crop_queue #(
  parameter int PIX_W     = 24,
  parameter int HOR_W     = 11,
  parameter int VER_W     = 9,
  parameter int FRAME_W   = 640,
  parameter int FRAME_H   = 480,
  parameter int ROI_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [HOR_W-1:0] HorMinIn,
  input  logic [HOR_W-1:0] HorMaxIn,
  input  logic [VER_W-1:0] VerMinIn,
  input  logic [VER_W-1:0] VerMaxIn,
  output logic             frame_request,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic             de_in,
  input  logic             vsync_in,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [PIX_W-1:0] pixel_out,
  output logic             de_out,
  output logic             vsync_out,
  output logic [HOR_W-1:0] OutWidth,
  output logic [VER_W-1:0] OutHeight,
  output logic             roi_error
);

  localparam int AW = $clog2(ROI_DEPTH);
  localparam logic [HOR_W-1:0] H_LAST = HOR_W'(FRAME_W - 1);
  localparam logic [VER_W-1:0] V_LAST = VER_W'(FRAME_H - 1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(ROI_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_STREAM
  } state_e;

  typedef struct packed {
    logic [HOR_W-1:0] hmin;
    logic [HOR_W-1:0] hmax;
    logic [VER_W-1:0] vmin;
    logic [VER_W-1:0] vmax;
  } box_t;

  box_t             fifo_q [ROI_DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;

  state_e           state_q, state_d;
  box_t             box_q, box_d, box_in, head;
  logic [HOR_W-1:0] x_q, x_d;
  logic [VER_W-1:0] y_q, y_d;
  logic [HOR_W-1:0] width_q, width_d;
  logic [VER_W-1:0] height_q, height_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             freq_q, freq_d;
  logic             vso_q, vso_d;
  logic             deo_q, deo_d;
  logic             err_q, err_d;
  logic             vs_q;

  logic             accept, bad, push, pop;
  logic             vs_rise, in_box, at_last;

  // Only the max edges can leave the frame; a min beyond the clamped
  // max turns into a rejected box.
  always_comb begin
    box_in.hmin = HorMinIn;
    box_in.hmax = (HorMaxIn > H_LAST) ? H_LAST : HorMaxIn;
    box_in.vmin = VerMinIn;
    box_in.vmax = (VerMaxIn > V_LAST) ? V_LAST : VerMaxIn;
  end

  assign ready_out = !rst && (cnt_q != CNT_FULL);
  assign accept    = valid_in && ready_out;
  assign bad       = (box_in.hmin > box_in.hmax) ||
                     (box_in.vmin > box_in.vmax);
  assign push      = accept && !bad;
  assign pop       = (state_q == S_IDLE) && (cnt_q != '0) && ready_in;
  assign head      = fifo_q[rptr_q];

  assign vs_rise   = vsync_in && !vs_q;
  assign in_box    = (x_q >= box_q.hmin) && (x_q <= box_q.hmax) &&
                     (y_q >= box_q.vmin) && (y_q <= box_q.vmax);
  assign at_last   = (x_q == box_q.hmax) && (y_q == box_q.vmax);

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= box_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    box_d    = box_q;
    x_d      = x_q;
    y_d      = y_q;
    width_d  = width_q;
    height_d = height_q;
    pix_d    = pix_q;
    freq_d   = 1'b0;
    vso_d    = 1'b0;
    deo_d    = 1'b0;
    err_d    = accept && bad;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          box_d    = head;
          width_d  = head.hmax - head.hmin + HOR_W'(1);
          height_d = head.vmax - head.vmin + VER_W'(1);
          freq_d   = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (vs_rise) begin
          x_d     = '0;
          y_d     = '0;
          vso_d   = 1'b1;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        // A new frame edge before the box completed means the
        // source truncated the frame; drop the box.
        if (vs_rise) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (de_in) begin
          if (in_box) begin
            deo_d = 1'b1;
            pix_d = pixel_in;
          end
          if (x_q == H_LAST) begin
            x_d = '0;
            y_d = y_q + VER_W'(1);
          end else begin
            x_d = x_q + HOR_W'(1);
          end
          if (at_last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      box_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      width_q  <= '0;
      height_q <= '0;
      pix_q    <= '0;
      freq_q   <= 1'b0;
      vso_q    <= 1'b0;
      deo_q    <= 1'b0;
      err_q    <= 1'b0;
      vs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      box_q    <= box_d;
      x_q      <= x_d;
      y_q      <= y_d;
      width_q  <= width_d;
      height_q <= height_d;
      pix_q    <= pix_d;
      freq_q   <= freq_d;
      vso_q    <= vso_d;
      deo_q    <= deo_d;
      err_q    <= err_d;
      vs_q     <= vsync_in;
    end
  end

  assign valid_out     = (state_q != S_IDLE);
  assign frame_request = freq_q;
  assign vsync_out     = vso_q;
  assign de_out        = deo_q;
  assign pixel_out     = pix_q;
  assign OutWidth      = width_q;
  assign OutHeight     = height_q;
  assign roi_error     = err_q;

endmodule

// File: tb/tb_roi_crop_queue.sv
// tb_roi_crop_queue: directed boxes against a ramp source
// (pixel = y*FW+x); scoreboard queues checked by a monitor.
module tb_roi_crop_queue;
  localparam int PIX_W = 24;
  localparam int HOR_W = 11;
  localparam int VER_W = 9;
  localparam int FW    = 640;
  localparam int FH    = 24;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             valid_in = 1'b0;
  logic             ready_out;
  logic [HOR_W-1:0] HorMinIn = '0, HorMaxIn = '0;
  logic [VER_W-1:0] VerMinIn = '0, VerMaxIn = '0;
  logic             frame_request;
  logic [PIX_W-1:0] pixel_in = '0;
  logic             de_in = 1'b0;
  logic             vsync_in = 1'b0;
  logic             ready_in = 1'b0;
  logic             valid_out;
  logic [PIX_W-1:0] pixel_out;
  logic             de_out;
  logic             vsync_out;
  logic [HOR_W-1:0] OutWidth;
  logic [VER_W-1:0] OutHeight;
  logic             roi_error;

  always #5 clk = ~clk;

  roi_crop_queue #(
    .PIX_W(PIX_W), .HOR_W(HOR_W), .VER_W(VER_W),
    .FRAME_W(FW), .FRAME_H(FH), .ROI_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .ready_out(ready_out),
    .HorMinIn(HorMinIn), .HorMaxIn(HorMaxIn),
    .VerMinIn(VerMinIn), .VerMaxIn(VerMaxIn),
    .frame_request(frame_request),
    .pixel_in(pixel_in), .de_in(de_in), .vsync_in(vsync_in),
    .ready_in(ready_in),
    .valid_out(valid_out), .pixel_out(pixel_out),
    .de_out(de_out), .vsync_out(vsync_out),
    .OutWidth(OutWidth), .OutHeight(OutHeight),
    .roi_error(roi_error)
  );

  typedef struct {
    int px;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   dim_q[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int n_freq = 0, n_vs = 0, n_err = 0;
  int freq_cyc = 0, vs_cyc = 0, err_cyc = 0;
  int hs_cyc = 0, rise_cyc = 0;
  int last_px = -1;
  int err_vo = -1;
  int trunc_line = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint got,
                     input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic push_box(input int h0, input int h1, input int v0,
                          input int v1, input int stop);
    exp_t e;
    dim_q.push_back(((h1 - h0 + 1) << 16) | (v1 - v0 + 1));
    for (int y = v0; y <= v1; y++) begin
      if (y < stop) begin
        for (int x = h0; x <= h1; x++) begin
          e.px   = y * FW + x;
          e.last = (x == h1) && (y == v1);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  // Monitor: every DUT output event is matched against the queues.
  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (de_out) begin
      if (exp_q.size() == 0) begin
        chk("spurious_de_out", de_out, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pixel_out", pixel_out, e.px);
        chk("valid_out_at_pixel", valid_out, e.last ? 0 : 1);
        if (e.last) last_px = int'(pixel_out);
      end
    end
    if (frame_request) begin
      n_freq++;
      freq_cyc = cyc;
      if (dim_q.size() == 0) begin
        chk("spurious_frame_request", frame_request, 0);
      end else begin
        d = dim_q.pop_front();
        chk("OutWidth", OutWidth, d >>> 16);
        chk("OutHeight", OutHeight, d & 16'hffff);
      end
    end
    if (vsync_out) begin
      n_vs++;
      vs_cyc = cyc;
    end
    if (roi_error) begin
      n_err++;
      err_cyc = cyc;
      err_vo  = int'(valid_out);
    end
  end

  // Ramp source: one frame per frame_request, stops once the
  // crop finishes; optionally truncated by an early vsync edge.
  initial begin
    bit go;
    forever begin
      @(negedge clk);
      if (frame_request) begin
        vsync_in = 1'b0;
        @(negedge clk);
        vsync_in = 1'b1;
        rise_cyc = cyc;
        @(negedge clk);
        @(negedge clk);
        vsync_in = 1'b0;
        go = 1'b1;
        for (int y = 0; y < FH && go; y++) begin
          for (int x = 0; x < FW && go; x++) begin
            if (trunc_line != 0 && y == trunc_line) begin
              de_in      = 1'b0;
              vsync_in   = 1'b1;
              trunc_line = 0;
              go         = 1'b0;
            end else begin
              de_in    = 1'b1;
              pixel_in = PIX_W'(y * FW + x);
              @(negedge clk);
              if (!valid_out) go = 1'b0;
            end
          end
        end
        de_in = 1'b0;
      end
    end
  end

  task automatic send_box(input int h0, input int h1, input int v0,
                          input int v1);
    int n = 0;
    valid_in = 1'b1;
    HorMinIn = HOR_W'(h0);
    HorMaxIn = HOR_W'(h1);
    VerMinIn = VER_W'(v0);
    VerMaxIn = VER_W'(v1);
    while (!ready_out && n < 50000) begin
      @(negedge clk);
      n++;
    end
    if (!ready_out) begin
      chk("handshake_timeout", ready_out, 1);
    end else begin
      @(negedge clk);
      hs_cyc = cyc;
    end
    valid_in = 1'b0;
  endtask

  task automatic wait_done(input int nreq);
    int n = 0;
    while (!(n_freq >= nreq && !valid_out && exp_q.size() == 0) &&
           n < 40000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("frames_requested", n_freq, nreq);
    chk("pixels_drained", exp_q.size(), 0);
    chk("idle_valid_out", valid_out, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid_out"}, valid_out, 0);
    chk({tag, "_de_out"}, de_out, 0);
    chk({tag, "_vsync_out"}, vsync_out, 0);
    chk({tag, "_frame_request"}, frame_request, 0);
    chk({tag, "_roi_error"}, roi_error, 0);
    chk({tag, "_pixel_out"}, pixel_out, 0);
    chk({tag, "_OutWidth"}, OutWidth, 0);
    chk({tag, "_OutHeight"}, OutHeight, 0);
    chk({tag, "_ready_out"}, ready_out, 0);
  endtask

  initial begin
    int e0, v0, f0, n;

    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", ready_out, 1);
    ready_in = 1'b1;

    // small box, ramp pixels 3210..3213 and 3850..3853
    push_box(10, 13, 5, 6, FH);
    send_box(10, 13, 5, 6);
    wait_done(1);
    chk("t1_req_latency", freq_cyc - hs_cyc, 1);
    chk("t1_vsync_latency", vs_cyc - rise_cyc, 1);
    chk("t1_vsync_count", n_vs, 1);
    chk("t1_last_px", last_px, 3853);
    chk("t1_err", n_err, 0);

    // max edges clamp to 639 / FH-1; last pixel is the frame's last
    push_box(600, 639, 20, 23, FH);
    send_box(600, 700, 20, 500);
    wait_done(2);
    chk("t2_last_px", last_px, 15359);
    chk("t2_err", n_err, 0);

    // rejected boxes: no push, one error pulse each
    e0 = n_err;
    send_box(20, 10, 0, 0);
    repeat (4) @(negedge clk);
    chk("t3_err_count", n_err, e0 + 1);
    chk("t3_err_latency", err_cyc - hs_cyc, 0);
    chk("t3_ready", ready_out, 1);
    send_box(700, 800, 0, 0);
    send_box(0, 5, 30, 20);
    repeat (4) @(negedge clk);
    chk("t3_err_count2", n_err, e0 + 3);
    chk("t3_no_request", n_freq, 2);

    // fill the FIFO while downstream is not ready
    ready_in = 1'b0;
    push_box(0, 1, 0, 0, FH);
    send_box(0, 1, 0, 0);
    push_box(2, 3, 0, 0, FH);
    send_box(2, 3, 0, 0);
    push_box(4, 4, 1, 1, FH);
    send_box(4, 4, 1, 1);
    push_box(5, 7, 2, 2, FH);
    send_box(5, 7, 2, 2);
    chk("t4_full", ready_out, 0);
    chk("t4_no_pop", n_freq, 2);
    push_box(8, 8, 3, 3, FH);
    fork
      send_box(8, 8, 3, 3);
      begin
        repeat (5) @(negedge clk);
        chk("t4_held", ready_out, 0);
        ready_in = 1'b1;
        @(negedge clk);
        chk("t4_ready_on_pop", ready_out, 1);
      end
    join
    wait_done(7);
    chk("t4_last_px", last_px, 1928);
    chk("t4_err", n_err, e0 + 3);

    // truncated frame aborts; next box needs a fresh vsync edge
    e0 = n_err;
    v0 = n_vs;
    trunc_line = 10;
    push_box(0, 639, 0, 23, 10);
    push_box(0, 3, 0, 0, FH);
    send_box(0, 639, 0, 23);
    send_box(0, 3, 0, 0);
    n = 0;
    while (n_err == e0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("t5_abort_err", n_err, e0 + 1);
    chk("t5_valid_at_abort", err_vo, 0);
    wait_done(9);
    chk("t5_vsync_count", n_vs, v0 + 2);
    chk("t5_err_total", n_err, e0 + 1);
    chk("t5_last_px", last_px, 3);

    // reset in the middle of streaming, with a box still queued
    e0 = n_err;
    f0 = n_freq;
    v0 = n_vs;
    push_box(0, 639, 5, 5, 0);
    send_box(0, 639, 5, 5);
    n = 0;
    while (n_vs == v0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_streaming", n_vs, v0 + 1);
    repeat (20) @(negedge clk);
    send_box(1, 1, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("t6");
    rst = 1'b0;
    @(negedge clk);
    chk("t6_ready_after_rst", ready_out, 1);
    repeat (30) @(negedge clk);
    chk("t6_fifo_flushed", n_freq, f0 + 1);
    chk("t6_no_err", n_err, e0);
    chk("t6_valid_out", valid_out, 0);
    chk("t6_no_pixels", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
